mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sits between the multicycle MIPS CPU core and the byte-addressed tiny RAM.
- Arbitrates the instruction-fetch port and the data port onto the single RAM port, which has one read/write interface and registered read data.
- Sequences each access as request, issue and complete, using per-master waitrequest handshakes.
- Rejects misaligned accesses before they reach the RAM.

Parameters:
- MAX_DATA_STREAK, 4: maximum consecutive data grants while a fetch is pending; the next grant then goes to fetch.
- ADDR_W, 32: address width on all ports.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_address  in  ADDR_W  fetch word address.
- i_read  in  1  fetch request.
- i_readdata  out  32  fetch data, valid when i_waitrequest=0.
- i_waitrequest  out  1  fetch stall.
- d_address  in  ADDR_W  data word address.
- d_byteenable  in  4  data byte lanes.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_writedata  in  32  data write value.
- d_readdata  out  32  data read value, valid when d_waitrequest=0.
- d_waitrequest  out  1  data stall.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  4  RAM byte lanes.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_writedata  out  32  RAM write value.
- mem_readdata  in  32  RAM read value; valid in the cycle after the mem_read edge.
- misalign_err  out  1  sticky flag: a misaligned access was rejected.

Behaviour:
- Reset (asynchronous, active-high) forces, immediately on assertion:
  - state=IDLE, owner=FETCH, streak=0;
  - mem_read=0, mem_write=0, mem_address=0, mem_byteenable=0, mem_writedata=0;
  - i_waitrequest=1, d_waitrequest=1, i_readdata=0, d_readdata=0, misalign_err=0.
- Reset mid-transaction abandons the transaction; a RAM strobe is never held across reset.
- State machine: IDLE -> ISSUE -> DONE -> IDLE. No back-to-back issue; peak throughput is 1 access per 3 cycles.
- IDLE, grant selection:
  - Data request (d_read|d_write) wins over fetch (i_read).
  - Exception: if streak==MAX_DATA_STREAK and i_read=1, fetch wins.
  - streak increments on each data grant while i_read=1, and clears on any fetch grant or when i_read=0 at a grant.
  - The winner's command is latched into the mem_* registers and the state moves to ISSUE.
  - No request: stay in IDLE.
- ISSUE: mem_read or mem_write is asserted for exactly this one cycle, then the state moves to DONE.
- DONE: the owner's waitrequest=0 for exactly one cycle.
  - Reads: owner readdata = mem_readdata, registered into the owner's readdata output and held until that owner's next completion.
  - Then the state returns to IDLE.
- Waitrequest is 1 in every other cycle, for both masters, whether or not they are requesting.
- Latency: a request sampled in IDLE at cycle N completes in cycle N+2. A losing master waits a further 3 cycles per preceding grant.
- Fetch commands: mem_byteenable is forced to 4'b1111 and mem_write=0.
- Data commands: d_byteenable passes through unchanged.
- Endianness: the byte-lane mapping and swap are the RAM's job; the arbiter passes data unmodified.
- Misaligned access: a granted request with address[1:0]!=0 is not issued.
  - ISSUE drives no strobe.
  - DONE completes normally with readdata=0.
  - misalign_err sets and stays set until reset.
- Data byteenable==0: issued as a no-op; the strobe is suppressed and the access completes normally.
- d_read and d_write both high: treated as a write; mem_read stays 0.
- Master drops its request while stalled: the latched transaction still completes; the completion pulse is harmless and that cycle's readdata is ignored.
- Master keeps its request high after completion: this is a new request, eligible at the next IDLE.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE, DONE};
  - owner enum {FETCH, DATA};
  - BE_WORD=4'b1111 and BE_NONE=4'b0000 constants.
- Sub-module mem_arb_pick: combinational grant choice plus the registered streak counter. Inputs: i_read, d_req, grant_strobe; outputs: grant_data.
- The FSM, command latch and response registers stay in mem_port_arbiter.

Test Plan:
- Fetch read alone, i_address=0x10, RAM word 0x8C020004 -> mem_read high at cycle N+1 with mem_byteenable=1111; i_waitrequest=0 and i_readdata=0x8C020004 at N+2.
- Simultaneous i_read and d_write (addr 0x20, be=0011, data 0x12330304) -> data is granted first (mem_write at N+1, d_waitrequest low at N+2); fetch is issued at N+4 and completes at N+5.
- Data requests held continuously with i_read held -> after 4 data completions the fifth grant is fetch; streak then resets.
- d_read at 0x22 -> no mem_read strobe; completes at N+2 with d_readdata=0; misalign_err=1 and stays 1 after further good accesses.
- Reset asserted during ISSUE of a write -> mem_write falls with no clock edge; all outputs take their reset values; the RAM word is unchanged.
- d_read=d_write=1 at 0x30, be=1111, data 0xDEADBEEF -> only mem_write pulses; a subsequent read of 0x30 returns 0xDEADBEEF.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   state_e       : access sequencer states (IDLE -> ISSUE -> DONE)
//   owner_e       : which master owns the current access
//   BE_WORD/NONE  : full-word and empty byte-enable patterns
//   is_misaligned : true when a word address has non-zero low bits
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: all bus signals around the arbiter.
//   i_*   : instruction-fetch port (CPU side, read only)
//   d_*   : data port (CPU side, read/write)
//   mem_* : single RAM port (RAM has registered read data)
// Modports:
//   slave  : the arbiter's view (takes CPU requests, drives the RAM)
//   master : the environment's view (CPU masters plus the RAM)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic [31:0]       i_readdata;
  logic              i_waitrequest;

  logic [ADDR_W-1:0] d_address;
  logic [3:0]        d_byteenable;
  logic              d_read;
  logic              d_write;
  logic [31:0]       d_writedata;
  logic [31:0]       d_readdata;
  logic              d_waitrequest;

  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;

  modport slave (
    input  i_address, i_read,
    output i_readdata, i_waitrequest,
    input  d_address, d_byteenable, d_read, d_write, d_writedata,
    output d_readdata, d_waitrequest,
    output mem_address, mem_byteenable, mem_read, mem_write, mem_writedata,
    input  mem_readdata
  );

  modport master (
    output i_address, i_read,
    input  i_readdata, i_waitrequest,
    output d_address, d_byteenable, d_read, d_write, d_writedata,
    input  d_readdata, d_waitrequest,
    input  mem_address, mem_byteenable, mem_read, mem_write, mem_writedata,
    output mem_readdata
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: grant choice between fetch and data plus the streak counter
// that stops data from starving a pending fetch.
//   clk, reset   : clock, async active-high reset
//   i_read       : fetch request pending
//   d_req        : data request pending (read or write)
//   grant_strobe : a grant is being taken this cycle
//   grant_data   : 1 = data wins, 0 = fetch wins (valid when a request exists)
module mem_arb_pick #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_read,
  input  logic d_req,
  input  logic grant_strobe,
  output logic grant_data
);

  localparam int STREAK_W = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                at_max_s;

  assign at_max_s = (streak_q == STREAK_MAX);

  // Data normally wins; once the streak limit is hit a pending fetch goes first.
  always_comb begin
    grant_data = d_req && !(at_max_s && i_read);
  end

  // Streak only grows while a fetch is actually being held off.
  always_comb begin
    streak_d = streak_q;
    if (grant_strobe) begin
      if (grant_data && i_read) begin
        if (at_max_s) begin
          streak_d = streak_q;
        end else begin
          streak_d = streak_q + {{(STREAK_W-1){1'b0}}, 1'b1};
        end
      end else begin
        streak_d = {STREAK_W{1'b0}};
      end
    end else begin
      streak_d = streak_q;
    end
  end

  // Streak counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q <= {STREAK_W{1'b0}};
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between the CPU fetch and data ports.
// Each access runs IDLE (grant + latch) -> ISSUE (one-cycle strobe) ->
// DONE (owner's waitrequest low for one cycle), so a request sampled in IDLE
// completes two cycles later. Misaligned accesses are never strobed.
//   clk, reset   : clock, async active-high reset
//   bus (slave)  : fetch port, data port and RAM port signals
//   misalign_err : sticky flag, a misaligned access was rejected
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int ADDR_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus,
  output logic                 misalign_err
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              cmd_read_q, cmd_read_d;
  logic              cmd_ok_q, cmd_ok_d;
  logic              i_wait_q, i_wait_d;
  logic              d_wait_q, d_wait_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              misalign_q, misalign_d;

  logic              d_req_s;
  logic              grant_strobe_s;
  logic              grant_data_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [3:0]        sel_be_s;
  logic [31:0]       sel_wdata_s;
  logic              sel_is_read_s;
  logic              sel_is_write_s;
  logic              sel_bad_s;
  logic              sel_ok_s;
  logic [31:0]       rdata_s;
  logic [31:0]       i_rdata_s;
  logic [31:0]       d_rdata_s;

  assign d_req_s        = bus.d_read | bus.d_write;
  assign grant_strobe_s = (state_q == IDLE) && (bus.i_read || d_req_s);

  mem_arb_pick #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_pick (
    .clk          (clk),
    .reset        (reset),
    .i_read       (bus.i_read),
    .d_req        (d_req_s),
    .grant_strobe (grant_strobe_s),
    .grant_data   (grant_data_s)
  );

  // Command of the winning master; write takes precedence when both d_read and d_write are set.
  always_comb begin
    if (grant_data_s) begin
      sel_addr_s     = bus.d_address;
      sel_be_s       = bus.d_byteenable;
      sel_wdata_s    = bus.d_writedata;
      sel_is_write_s = bus.d_write;
      sel_is_read_s  = bus.d_read & ~bus.d_write;
    end else begin
      sel_addr_s     = bus.i_address;
      sel_be_s       = BE_WORD;
      sel_wdata_s    = 32'h0000_0000;
      sel_is_write_s = 1'b0;
      sel_is_read_s  = 1'b1;
    end
    sel_bad_s = is_misaligned(sel_addr_s[1:0]);
    // A strobe goes out only for an aligned access that touches at least one lane.
    sel_ok_s  = !sel_bad_s && (sel_be_s != BE_NONE);
  end

  // Read return path. The RAM's registered data is only valid during DONE,
  // so it is passed straight to the owner in that cycle and captured into the
  // hold register at the same edge; outside DONE the held value is shown.
  // Suppressed reads (misaligned or empty byte-enable) return zero.
  always_comb begin
    if (cmd_ok_q) begin
      rdata_s = bus.mem_readdata;
    end else begin
      rdata_s = 32'h0000_0000;
    end
    if ((state_q == DONE) && (owner_q == FETCH) && cmd_read_q) begin
      i_rdata_s = rdata_s;
    end else begin
      i_rdata_s = i_rdata_q;
    end
    if ((state_q == DONE) && (owner_q == DATA) && cmd_read_q) begin
      d_rdata_s = rdata_s;
    end else begin
      d_rdata_s = d_rdata_q;
    end
  end

  // Sequencer next-state, command latch and response control.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    mem_address_d = mem_address_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    cmd_read_d    = cmd_read_q;
    cmd_ok_d      = cmd_ok_q;
    i_wait_d      = 1'b1;
    d_wait_d      = 1'b1;
    i_rdata_d     = i_rdata_s;
    d_rdata_d     = d_rdata_s;
    misalign_d    = misalign_q;
    case (state_q)
      IDLE: begin
        if (grant_strobe_s) begin
          state_d       = ISSUE;
          owner_d       = grant_data_s ? DATA : FETCH;
          mem_address_d = sel_addr_s;
          mem_be_d      = sel_be_s;
          mem_wdata_d   = sel_wdata_s;
          mem_read_d    = sel_is_read_s & sel_ok_s;
          mem_write_d   = sel_is_write_s & sel_ok_s;
          cmd_read_d    = sel_is_read_s;
          cmd_ok_d      = sel_ok_s;
          misalign_d    = misalign_q | sel_bad_s;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // Strobe drops here; the owner's completion pulse is set up for DONE.
        state_d  = DONE;
        i_wait_d = (owner_q != FETCH);
        d_wait_d = (owner_q != DATA);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any RAM strobe immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= FETCH;
      mem_address_q <= {ADDR_W{1'b0}};
      mem_be_q      <= BE_NONE;
      mem_wdata_q   <= 32'h0000_0000;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      cmd_read_q    <= 1'b0;
      cmd_ok_q      <= 1'b0;
      i_wait_q      <= 1'b1;
      d_wait_q      <= 1'b1;
      i_rdata_q     <= 32'h0000_0000;
      d_rdata_q     <= 32'h0000_0000;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      mem_address_q <= mem_address_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      cmd_read_q    <= cmd_read_d;
      cmd_ok_q      <= cmd_ok_d;
      i_wait_q      <= i_wait_d;
      d_wait_q      <= d_wait_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      misalign_q    <= misalign_d;
    end
  end

  assign bus.mem_address    = mem_address_q;
  assign bus.mem_byteenable = mem_be_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_writedata  = mem_wdata_q;
  assign bus.i_waitrequest  = i_wait_q;
  assign bus.d_waitrequest  = d_wait_q;
  assign bus.i_readdata     = i_rdata_s;
  assign bus.d_readdata     = d_rdata_s;
  assign misalign_err       = misalign_q;

endmodule
